// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: state encoding, default
// operand width and the iteration-counter width helper.
package seq_divider_pkg;

  localparam int WIDTH_DEF = 8;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/seq_divider_if.sv
// go/over handshake bundle for the sequential divider, shared in shape with
// the Booth multiplier so both blocks sequence identically.
interface seq_divider_if #(parameter int WIDTH = 8);
  logic                   go;
  logic [2*WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]       divisor;
  logic [WIDTH-1:0]       quotient;
  logic [WIDTH-1:0]       remainder;
  logic                   over;
  logic                   div0;
  logic                   ovf;

  modport master (
    output go, dividend, divisor,
    input  quotient, remainder, over, div0, ovf
  );

  modport slave (
    input  go, dividend, divisor,
    output quotient, remainder, over, div0, ovf
  );
endinterface

// File: rtl/seq_divider_addsub.sv
// div_addsub: combinational add/subtract cell shared by the non-restoring
// iteration and the final remainder correction.
module div_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] sum_o
);

  // Single adder; subtract selects a - b, otherwise a + b (modulo 2^N).
  always_comb begin
    if (sub_i) begin
      sum_o = a_i - b_i;
    end else begin
      sum_o = a_i + b_i;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: 2W/W non-restoring divider with go/over handshake.
// Optional macro DIV_SIGNED_EN enables two's-complement operation; without it
// the unit divides unsigned operands with identical latency.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic          clk,
  input logic          clr,
  seq_divider_if.slave dbus
);

  localparam int             W2       = 2 * WIDTH;
  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_e             state_q, state_d;
  logic               armed_q, armed_d;
  logic [W2-1:0]      dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH:0]     p_q, p_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               pre_ovf_q, pre_ovf_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               over_q, over_d;
  logic               div0_q, div0_d;
  logic               ovf_q, ovf_d;

  logic [W2-1:0]      dvd_mag_s;
  logic [WIDTH-1:0]   dvs_mag_s;
  logic [WIDTH-1:0]   rem_mag_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic               ovf_fix_s;
  logic [WIDTH:0]     as_a_s, as_b_s, as_sum_s;
  logic               as_sub_s;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic nsign_q, nsign_d;
  logic dsign_q, dsign_d;
  logic qneg_s;

  // Magnitudes of the captured operands (most negative values fit unsigned).
  always_comb begin
    if (dvd_q[W2-1]) begin
      dvd_mag_s = {W2{1'b0}} - dvd_q;
    end else begin
      dvd_mag_s = dvd_q;
    end
    if (dvs_q[WIDTH-1]) begin
      dvs_mag_s = {WIDTH{1'b0}} - dvs_q;
    end else begin
      dvs_mag_s = dvs_q;
    end
  end

  // Operand signs are recorded in LOAD and used by the sign-fix cycle.
  always_comb begin
    nsign_d = nsign_q;
    dsign_d = dsign_q;
    if (state_q == ST_LOAD) begin
      nsign_d = dvd_q[W2-1];
      dsign_d = dvs_q[WIDTH-1];
    end else begin
      nsign_d = nsign_q;
      dsign_d = dsign_q;
    end
  end

  // Sign registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      nsign_q <= 1'b0;
      dsign_q <= 1'b0;
    end else begin
      nsign_q <= nsign_d;
      dsign_q <= dsign_d;
    end
  end

  // Apply signs and detect an unrepresentable signed quotient.
  always_comb begin
    qneg_s = nsign_q ^ dsign_q;
    if (qneg_s) begin
      quo_fix_s = {WIDTH{1'b0}} - q_q;
    end else begin
      quo_fix_s = q_q;
    end
    if (nsign_q) begin
      rem_fix_s = {WIDTH{1'b0}} - rem_mag_s;
    end else begin
      rem_fix_s = rem_mag_s;
    end
    ovf_fix_s = pre_ovf_q
              | (~qneg_s & (q_q > MAX_POS))
              | ( qneg_s & (q_q > MAX_NEG));
  end
`else
  assign dvd_mag_s = dvd_q;
  assign dvs_mag_s = dvs_q;
  assign quo_fix_s = q_q;
  assign rem_fix_s = rem_mag_s;
  assign ovf_fix_s = pre_ovf_q;
`endif

  // Adder operands: shifted remainder +/- divisor in ITER, correction add in FIX.
  always_comb begin
    as_a_s   = p_q;
    as_b_s   = {1'b0, d_q};
    as_sub_s = 1'b0;
    if (state_q == ST_ITER) begin
      as_a_s   = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
      as_sub_s = ~p_q[WIDTH];
    end else begin
      as_a_s   = p_q;
      as_sub_s = 1'b0;
    end
  end

  div_addsub #(.N(WIDTH + 1)) u_addsub (
    .a_i   (as_a_s),
    .b_i   (as_b_s),
    .sub_i (as_sub_s),
    .sum_o (as_sum_s)
  );

  // A negative final partial remainder is pulled back into [0, divisor).
  always_comb begin
    if (p_q[WIDTH]) begin
      rem_mag_s = as_sum_s[WIDTH-1:0];
    end else begin
      rem_mag_s = p_q[WIDTH-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; ITER runs exactly WIDTH cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dbus.go && armed_q) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: state_d = ST_ITER;
      ST_ITER: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_ITER;
        end
      end
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: begin
        if (dbus.go) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output/datapath next values per state.
  always_comb begin
    armed_d   = armed_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    p_d       = p_q;
    q_d       = q_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    pre_ovf_d = pre_ovf_q;
    zero_d    = zero_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (!dbus.go) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          dvd_d   = dbus.dividend;
          dvs_d   = dbus.divisor;
        end else begin
          armed_d = armed_q;
        end
      end
      ST_LOAD: begin
        p_d       = {1'b0, dvd_mag_s[W2-1:WIDTH]};
        q_d       = dvd_mag_s[WIDTH-1:0];
        d_d       = dvs_mag_s;
        cnt_d     = CNT_INIT;
        zero_d    = (dvs_q == {WIDTH{1'b0}});
        pre_ovf_d = (dvd_mag_s[W2-1:WIDTH] >= dvs_mag_s);
        quo_d     = {WIDTH{1'b0}};
        rem_d     = {WIDTH{1'b0}};
        div0_d    = 1'b0;
        ovf_d     = 1'b0;
      end
      ST_ITER: begin
        p_d   = as_sum_s;
        q_d   = {q_q[WIDTH-2:0], ~as_sum_s[WIDTH]};
        cnt_d = cnt_q - CNT_ONE;
      end
      ST_FIX: begin
        div0_d = zero_q;
        ovf_d  = ~zero_q & ovf_fix_s;
        if (zero_q || ovf_fix_s) begin
          quo_d = {WIDTH{1'b0}};
          rem_d = {WIDTH{1'b0}};
        end else begin
          quo_d = quo_fix_s;
          rem_d = rem_fix_s;
        end
      end
      ST_DONE: begin
        if (!dbus.go) begin
          armed_d = 1'b1;
        end else begin
          armed_d = armed_q;
        end
      end
      default: armed_d = armed_q;
    endcase
    over_d = (state_d == ST_DONE);
  end

  // Datapath and result registers; clr aborts and discards everything.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      armed_q   <= 1'b0;
      dvd_q     <= {W2{1'b0}};
      dvs_q     <= {WIDTH{1'b0}};
      p_q       <= {(WIDTH+1){1'b0}};
      q_q       <= {WIDTH{1'b0}};
      d_q       <= {WIDTH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      pre_ovf_q <= 1'b0;
      zero_q    <= 1'b0;
      quo_q     <= {WIDTH{1'b0}};
      rem_q     <= {WIDTH{1'b0}};
      over_q    <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      p_q       <= p_d;
      q_q       <= q_d;
      d_q       <= d_d;
      cnt_q     <= cnt_d;
      pre_ovf_q <= pre_ovf_d;
      zero_q    <= zero_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      over_q    <= over_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
    end
  end

  assign dbus.quotient  = quo_q;
  assign dbus.remainder = rem_q;
  assign dbus.over      = over_q;
  assign dbus.div0      = div0_q;
  assign dbus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=8); expectations follow the build's
// DIV_SIGNED_EN setting.
module tb_seq_divider;

  logic clk;
  logic clr;
  int   errors;
  int   checks;

  seq_divider_if #(.WIDTH(8)) dbus ();

  seq_divider #(.WIDTH(8)) dut (
    .clk  (clk),
    .clr  (clr),
    .dbus (dbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start an operation and return the number of edges after E0 until over.
  task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs, output int lat);
    @(negedge clk);
    dbus.dividend = dvd;
    dbus.divisor  = dvs;
    dbus.go       = 1'b1;
    @(posedge clk);
    #1;
    dbus.dividend = ~dvd;
    dbus.divisor  = dvs ^ 8'h5A;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (dbus.over === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic end_op();
    @(negedge clk);
    dbus.go = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_vector(input string name, input logic [15:0] dvd, input logic [7:0] dvs,
                             input logic [7:0] eq, input logic [7:0] er,
                             input logic ed0, input logic eovf);
    int lat;
    run_op(dvd, dvs, lat);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL %s_latency: got %0d want 10", name, lat);
    end
    checks++;
    if (dbus.quotient !== eq) begin
      errors++;
      $display("FAIL %s_quotient: got %h want %h", name, dbus.quotient, eq);
    end
    checks++;
    if (dbus.remainder !== er) begin
      errors++;
      $display("FAIL %s_remainder: got %h want %h", name, dbus.remainder, er);
    end
    checks++;
    if ({dbus.div0, dbus.ovf} !== {ed0, eovf}) begin
      errors++;
      $display("FAIL %s_flags: got div0=%b ovf=%b want div0=%b ovf=%b",
               name, dbus.div0, dbus.ovf, ed0, eovf);
    end
    end_op();
    checks++;
    if (dbus.over !== 1'b0) begin
      errors++;
      $display("FAIL %s_over_release: got %b want 0", name, dbus.over);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    dbus.go = 1'b0;
    dbus.dividend = 16'h0000;
    dbus.divisor  = 8'h00;
    #12;
    checks++;
    if ({dbus.over, dbus.div0, dbus.ovf, dbus.quotient, dbus.remainder} !== 19'h0) begin
      errors++;
      $display("FAIL reset_outputs: got over=%b div0=%b ovf=%b q=%h r=%h want all 0",
               dbus.over, dbus.div0, dbus.ovf, dbus.quotient, dbus.remainder);
    end
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat;
    run_op(16'd700, 8'd7, lat);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 10", lat);
    end
    checks++;
    if (dbus.quotient !== 8'd100 || dbus.remainder !== 8'd0) begin
      errors++;
      $display("FAIL basic_result: got q=%0d r=%0d want q=100 r=0", dbus.quotient, dbus.remainder);
    end
    checks++;
    if ({dbus.div0, dbus.ovf} !== 2'b00) begin
      errors++;
      $display("FAIL basic_flags: got %b want 00", {dbus.div0, dbus.ovf});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (dbus.over !== 1'b1 || dbus.quotient !== 8'd100) begin
      errors++;
      $display("FAIL basic_hold: got over=%b q=%0d want over=1 q=100", dbus.over, dbus.quotient);
    end
    end_op();
    checks++;
    if (dbus.over !== 1'b0) begin
      errors++;
      $display("FAIL basic_over_release: got %b want 0", dbus.over);
    end
  endtask

  task automatic test_abort();
    int lat;
    int seen;
    @(negedge clk);
    dbus.dividend = 16'd700;
    dbus.divisor  = 8'd7;
    dbus.go       = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if ({dbus.over, dbus.div0, dbus.ovf, dbus.quotient, dbus.remainder} !== 19'h0) begin
      errors++;
      $display("FAIL abort_outputs: got over=%b q=%h r=%h want all 0",
               dbus.over, dbus.quotient, dbus.remainder);
    end
    @(negedge clk);
    clr = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (dbus.over === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_start: got over high %0d cycles want 0", seen);
    end
    end_op();
    run_op(16'd1234, 8'd10, lat);
    checks++;
    if (lat !== 10 || dbus.quotient !== 8'd123 || dbus.remainder !== 8'd4) begin
      errors++;
      $display("FAIL abort_resume: got lat=%0d q=%0d r=%0d want lat=10 q=123 r=4",
               lat, dbus.quotient, dbus.remainder);
    end
    end_op();
  endtask

  task automatic test_back_to_back();
    test_vector("b2b_first", 16'd200, 8'd3, 8'd66, 8'd2, 1'b0, 1'b0);
    test_vector("b2b_second", 16'd255, 8'd16, 8'd15, 8'd15, 1'b0, 1'b0);
  endtask

  task automatic test_div0();
    test_vector("div0", 16'd100, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0);
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    test_vector("neg_dividend", 16'hFC18, 8'd33, 8'hE2, 8'hF6, 1'b0, 1'b0);
    test_vector("min_quotient", 16'hC080, 8'd127, 8'h80, 8'h00, 1'b0, 1'b0);
    test_vector("neg_divisor", 16'd300, 8'hF9, 8'hD6, 8'd6, 1'b0, 1'b0);
    test_vector("preovf", 16'd32767, 8'd1, 8'd0, 8'd0, 1'b0, 1'b1);
    test_vector("neg_range_ovf", 16'd1000, 8'hF9, 8'd0, 8'd0, 1'b0, 1'b1);
  endtask
`else
  task automatic test_unsigned();
    test_vector("u_preovf", 16'hFFFF, 8'hFF, 8'd0, 8'd0, 1'b0, 1'b1);
    test_vector("u_full_range", 16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0);
    test_vector("u_preovf_one", 16'd32767, 8'd1, 8'd0, 8'd0, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
`ifdef DIV_SIGNED_EN
    test_signed();
`else
    test_unsigned();
`endif
    test_div0();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential signed division unit; the inverse-operation companion to the team's radix-4 Booth multiplier.
- Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor and returns a WIDTH-bit quotient and a WIDTH-bit remainder.
- Uses the multiplier's go/over handshake and clk/clr scheme, so both blocks share the same top-level sequencing.
- Core is non-restoring division on operand magnitudes, followed by a sign-fix cycle.

Parameters:
- WIDTH, 8, divisor/quotient/remainder width; the dividend is 2*WIDTH bits.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- go  in  1  start request, level; also holds the result.
- dividend  in  2*WIDTH  two's-complement dividend.
- divisor  in  WIDTH  two's-complement divisor.
- quotient  out  WIDTH  registered quotient, truncated toward zero.
- remainder  out  WIDTH  registered remainder; its sign follows the dividend.
- over  out  1  result valid / operation complete.
- div0  out  1  divisor was zero.
- ovf  out  1  quotient not representable in WIDTH signed bits.

Behaviour:
- Reset (clr=0, async): state=IDLE, armed=0, all outputs 0, internal registers cleared.
- Reset mid-operation aborts immediately; no partial result is kept.
- States:
  - IDLE: sets armed=1 whenever go=0. If go=1 and armed=1, samples dividend/divisor at this edge (E0) and enters LOAD. go=1 with armed=0 (held high through reset) never starts an operation.
  - LOAD (1 cycle): forms magnitudes |dividend| (2*WIDTH bits unsigned) and |divisor|, records both signs, sets div0 = (divisor==0), sets preovf = (|dividend|[2W-1:W] >= |divisor|), loads iteration count = WIDTH.
  - ITER (WIDTH cycles): one non-restoring step per cycle on a (WIDTH+1)-bit partial remainder. Shift left, then add or subtract |divisor| according to the partial-remainder sign, and shift the quotient bit in. Count decrements; exit at count==0.
  - FIX (1 cycle):
    - Final remainder correction: add |divisor| back if negative.
    - Apply signs: quotient is negated if the operand signs differ; remainder is negated if the dividend is negative.
    - ovf = preovf OR (positive quotient magnitude > 2^(W-1)-1) OR (negative quotient magnitude > 2^(W-1)).
  - DONE: over=1. Stays in DONE while go=1; go=0 returns to IDLE with armed=1 and over=0 on the next edge.
- Latency is fixed: over rises at edge E0+WIDTH+2 (10 edges for WIDTH=8), for every case including div0/ovf.
- Outputs are loaded on entry to DONE and held until the next LOAD.
- If div0 or ovf is set: quotient=0, remainder=0, and only the applicable flag(s) are 1.
- The flags are mutually resolved: div0 forces ovf=0.
- Operand changes after E0 are ignored.
- -2^(W-1) is a legal quotient (e.g. -16256/127 = -128, no ovf).

Optional Feature:
- Macro DIV_SIGNED_EN.
- Defined: two's-complement operation as described above.
- Undefined: unsigned-only operation.
  - Magnitude and sign-fix logic is removed; FIX performs only the remainder correction.
  - ovf = preovf only.
  - Latency is unchanged, so the handshake stays identical.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, LOAD, ITER, FIX, DONE);
  - WIDTH default;
  - the iteration-counter width, clog2(WIDTH+1).
- One natural sub-module: div_addsub, a combinational (WIDTH+1)-bit add/subtract cell with a mode select, instantiated once in the ITER datapath and reused by FIX for the correction add.
- All control stays in seq_divider.

Test Plan:
- clr pulse low, go=0, then go=1 with dividend=700, divisor=7 -> over=1 after exactly 10 edges; quotient=100, remainder=0, div0=0, ovf=0.
- dividend=-1000, divisor=33 -> quotient=-30 (0xE2), remainder=-10 (0xF6), no flags.
- dividend=-16256, divisor=127 -> quotient=0x80, remainder=0, ovf=0. Then dividend=32767, divisor=1 -> ovf=1, quotient=0, remainder=0.
- dividend=100, divisor=0 -> div0=1, ovf=0, quotient=0, remainder=0, same 10-edge latency.
- clr pulsed low during ITER -> all outputs 0 immediately.
  - go held high through clr release -> no start.
  - go toggled low then high -> normal operation resumes with correct results.
- Build without DIV_SIGNED_EN: dividend=0xFFFF, divisor=0xFF -> ovf=1. Dividend=1000, divisor=7 -> quotient=142, remainder=6.
